// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Purpose:
//   Round-robin arbiter for a Tomasulo-style common data bus (CDB). NREQ
//   functional-unit result ports compete for the bus. The winner's tag and
//   data are registered and broadcast one cycle after the grant. The
//   register-file write port is derived combinationally from the broadcast.
//
// Handshake (valid/ready semantics):
//   i_req[i] acts as "valid" and o_grant[i] acts as "ready". A transfer
//   completes at the rising edge where both are 1. A requester keeps
//   i_req[i], its tag and its data stable until it is granted. In the cycle
//   after the grant it either drops i_req[i] or presents its next result.
//   When i_req[i] is 0, that requester's tag and data are ignored.
//
// Ports:
//   i_clock          single clock, rising-edge active
//   i_reset          asynchronous, active-high reset
//   i_req            per-requester result-ready bits
//   i_req_tag        per-requester destination tags, requester i at [i*TW +: TW]
//   i_req_data       per-requester results, requester i at [i*DW +: DW]
//   o_grant          combinational one-hot-or-zero grant; forced to 0 in reset
//   o_cdb_valid      a registered broadcast is on the bus this cycle
//   o_cdb_src        index of the requester being broadcast
//   o_cdb_tag        broadcast destination tag (0 means no register write)
//   o_cdb_data       broadcast result
//   o_rf_we          register-file write enable (valid and tag != 0)
//   o_rf_addr        register-file write address (the broadcast tag)
//   o_rf_data        register-file write data (the broadcast data)
//   o_bcast_count    completed grants, saturating at 16'hFFFF
//   o_dbg_ptr        current round-robin priority pointer (debug visibility)
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int TW   = 3,
  localparam int SW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ*TW-1:0] i_req_tag,
  input  logic [NREQ*DW-1:0] i_req_data,
  output logic [NREQ-1:0]    o_grant,
  output logic               o_cdb_valid,
  output logic [SW-1:0]      o_cdb_src,
  output logic [TW-1:0]      o_cdb_tag,
  output logic [DW-1:0]      o_cdb_data,
  output logic               o_rf_we,
  output logic [TW-1:0]      o_rf_addr,
  output logic [DW-1:0]      o_rf_data,
  output logic [15:0]        o_bcast_count,
  output logic [SW-1:0]      o_dbg_ptr
);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [SW-1:0] r_ptr;
  logic          r_cdb_valid;
  logic [SW-1:0] r_cdb_src;
  logic [TW-1:0] r_cdb_tag;
  logic [DW-1:0] r_cdb_data;
  logic [15:0]   r_bcast_count;

  // ---------------------------------------------------------------------------
  // Combinational arbitration
  // ---------------------------------------------------------------------------
  logic [NREQ-1:0] w_grant_raw;
  logic            w_found;
  logic [SW-1:0]   w_win_idx;
  logic [TW-1:0]   w_sel_tag;
  logic [DW-1:0]   w_sel_data;
  logic            w_hs;
  logic [SW-1:0]   w_ptr_next;

  // Search starts at r_ptr and wraps modulo NREQ. The first requester found
  // wins, so at most one grant bit can be set.
  always_comb begin
    logic [SW-1:0] v_idx;
    w_grant_raw = '0;
    w_found     = 1'b0;
    w_win_idx   = '0;
    v_idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      v_idx = SW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && i_req[v_idx]) begin
        w_found            = 1'b1;
        w_grant_raw[v_idx] = 1'b1;
        w_win_idx          = v_idx;
      end
    end
  end

  // Pick the winner's tag and data with a one-hot mux. A requester whose
  // i_req bit is 0 can never be selected here.
  always_comb begin
    w_sel_tag  = '0;
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant_raw[i]) begin
        w_sel_tag  = i_req_tag[i*TW +: TW];
        w_sel_data = i_req_data[i*DW +: DW];
      end
    end
  end

  // The grant is forced low during reset, even mid-handshake. This means a
  // handshake that coincides with reset can never be captured.
  assign o_grant = i_reset ? '0 : w_grant_raw;
  assign w_hs    = w_found & ~i_reset;

  // After a grant, priority moves to the requester just past the winner.
  assign w_ptr_next = (w_win_idx == SW'(NREQ - 1)) ? '0 : (w_win_idx + 1'b1);

  // ---------------------------------------------------------------------------
  // Pointer register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_ptr <= '0;
    end else if (w_hs) begin
      r_ptr <= w_ptr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Broadcast registers: valid follows the handshake every cycle; the payload
  // is loaded only on a handshake and otherwise holds its last value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cdb_valid <= 1'b0;
      r_cdb_src   <= '0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
    end else begin
      r_cdb_valid <= w_hs;
      if (w_hs) begin
        r_cdb_src  <= w_win_idx;
        r_cdb_tag  <= w_sel_tag;
        r_cdb_data <= w_sel_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Completed-grant counter, saturating rather than wrapping
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_bcast_count <= 16'd0;
    end else if (w_hs && (r_bcast_count != 16'hFFFF)) begin
      r_bcast_count <= r_bcast_count + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_cdb_valid   = r_cdb_valid;
  assign o_cdb_src     = r_cdb_src;
  assign o_cdb_tag     = r_cdb_tag;
  assign o_cdb_data    = r_cdb_data;
  assign o_bcast_count = r_bcast_count;
  assign o_dbg_ptr     = r_ptr;

  // Tag 0 still broadcasts, so reservation stations can wake up, but it has
  // no architectural destination and so does not write the register file.
  assign o_rf_we   = r_cdb_valid & (r_cdb_tag != '0);
  assign o_rf_addr = r_cdb_tag;
  assign o_rf_data = r_cdb_data;

endmodule
